// File: rtl/muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension unit: funct3 encodings,
// FSM state encoding and operand-signedness decode helpers.
package muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic rs1IsSigned(input logic [2:0] f3);
    return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic rs2IsSigned(input logic [2:0] f3);
    return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) ||
           (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic isDivOp(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic isRemOp(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and muldiv_seq.
interface muldiv_seq_if #(parameter int XLEN = 32);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [2:0]      funct3_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] c_o;
  logic            busy_o;

  modport slave (
    input  in_valid_i, rs1_i, rs2_i, funct3_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o, busy_o
  );

  modport master (
    output in_valid_i, rs1_i, rs2_i, funct3_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o, busy_o
  );

endinterface

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_bit,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  // i_rem < i_divisor always holds, so the top bit of w_diff is a clean borrow flag
  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign o_qbit    = ~w_diff[XLEN];
  assign o_rem     = o_qbit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// Handshaked M-extension unit: single-cycle multiply, iterative restoring divide.
// Optional result cache for repeated divide/remainder operands: MULDIV_REM_CACHE_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  localparam int              CNT_W     = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES  = '1;
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_c;
  logic                r_inReady;
  logic                r_outValid;
  logic                r_busy;
  logic [2:0]          r_funct3;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic                r_negA;
  logic                r_negB;
  logic [XLEN-1:0]     r_dq;
  logic [XLEN-1:0]     r_rem;

  logic                w_rs1Neg;
  logic                w_rs2Neg;
  logic [XLEN-1:0]     w_magA;
  logic [XLEN-1:0]     w_magB;
  logic                w_divByZero;
  logic                w_overflow;
  logic [XLEN-1:0]     w_specialRes;
  logic [2*XLEN-1:0]   w_prod;
  logic [2*XLEN-1:0]   w_prodSigned;
  logic [XLEN-1:0]     w_mulRes;
  logic [XLEN-1:0]     w_stepRem;
  logic                w_stepQ;
  logic [XLEN-1:0]     w_fixRes;
  logic                w_cacheHit;
  logic [XLEN-1:0]     w_cacheRes;

  // Unsigned ops carry neg flags of zero, so the sign rules reduce to these two tests
  function automatic logic [XLEN-1:0] fixResult(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic            negA,
    input logic            negB,
    input logic [2:0]      f3
  );
    if (isRemOp(f3)) return negA ? -r : r;
    return (negA ^ negB) ? -q : q;
  endfunction

  assign w_rs1Neg     = rs1IsSigned(bus.funct3_i) & bus.rs1_i[XLEN-1];
  assign w_rs2Neg     = rs2IsSigned(bus.funct3_i) & bus.rs2_i[XLEN-1];
  assign w_magA       = w_rs1Neg ? -bus.rs1_i : bus.rs1_i;
  assign w_magB       = w_rs2Neg ? -bus.rs2_i : bus.rs2_i;
  assign w_divByZero  = (bus.rs2_i == '0);
  assign w_overflow   = rs1IsSigned(bus.funct3_i) & (bus.rs1_i == MIN_NEG) &
                        (bus.rs2_i == ALL_ONES);
  assign w_specialRes = w_divByZero ? (isRemOp(bus.funct3_i) ? bus.rs1_i : ALL_ONES)
                                    : (isRemOp(bus.funct3_i) ? '0 : bus.rs1_i);

  assign w_prod       = {{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, r_b};
  assign w_prodSigned = (r_negA ^ r_negB) ? -w_prod : w_prod;
  assign w_mulRes     = (r_funct3 == FUNCT3_MUL) ? w_prodSigned[XLEN-1:0]
                                                 : w_prodSigned[2*XLEN-1:XLEN];

  assign w_fixRes     = fixResult(r_dq, r_rem, r_negA, r_negB, r_funct3);

  div_restoring_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_divisor (r_b),
    .i_bit     (r_dq[XLEN-1]),
    .o_rem     (w_stepRem),
    .o_qbit    (w_stepQ)
  );

`ifdef MULDIV_REM_CACHE_EN
  logic            r_cValid;
  logic [XLEN-1:0] r_cA;
  logic [XLEN-1:0] r_cB;
  logic [XLEN-1:0] r_cQ;
  logic [XLEN-1:0] r_cR;

  assign w_cacheHit = r_cValid & (w_magA == r_cA) & (w_magB == r_cB);
  assign w_cacheRes = fixResult(r_cQ, r_cR, w_rs1Neg, w_rs2Neg, bus.funct3_i);

  // Unsigned quotient/remainder are captured as FIX consumes them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cValid <= 1'b0;
      r_cA     <= '0;
      r_cB     <= '0;
      r_cQ     <= '0;
      r_cR     <= '0;
    end else if (r_state == S_FIX) begin
      r_cValid <= 1'b1;
      r_cA     <= r_a;
      r_cB     <= r_b;
      r_cQ     <= r_dq;
      r_cR     <= r_rem;
    end
  end
`else
  assign w_cacheHit = 1'b0;
  assign w_cacheRes = '0;
`endif

  // r_dq starts as the dividend magnitude and fills with quotient bits as it shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_c        <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_funct3   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_negA     <= 1'b0;
      r_negB     <= 1'b0;
      r_dq       <= '0;
      r_rem      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid_i) begin
            r_funct3  <= bus.funct3_i;
            r_a       <= w_magA;
            r_b       <= w_magB;
            r_negA    <= w_rs1Neg;
            r_negB    <= w_rs2Neg;
            r_dq      <= w_magA;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_inReady <= 1'b0;
            if (!isDivOp(bus.funct3_i)) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end else if (w_divByZero || w_overflow) begin
              r_c        <= w_specialRes;
              r_state    <= S_DONE;
              r_outValid <= 1'b1;
            end else if (w_cacheHit) begin
              r_c        <= w_cacheRes;
              r_state    <= S_DONE;
              r_outValid <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_c        <= w_mulRes;
          r_state    <= S_DONE;
          r_busy     <= 1'b0;
          r_outValid <= 1'b1;
        end
        S_DIV: begin
          r_rem <= w_stepRem;
          r_dq  <= {r_dq[XLEN-2:0], w_stepQ};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_c        <= w_fixRes;
          r_state    <= S_DONE;
          r_busy     <= 1'b0;
          r_outValid <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready_i) begin
            r_state    <= S_IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = r_inReady;
  assign bus.out_valid_o = r_outValid;
  assign bus.c_o         = r_c;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops
// scored against a plain-arithmetic reference. Honors MULDIV_REM_CACHE_EN.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int DIV_LAT = XLEN + 1;
  localparam int MAX_WAIT = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nVectors     = 0;
  int nMiscompares = 0;

  bit          cacheValid = 1'b0;
  logic [31:0] cacheA     = '0;
  logic [31:0] cacheB     = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the ISA definition using 64-bit arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          p;
    longint unsigned up;
    case (f3)
      FUNCT3_MUL:    begin p = sa * sb; return p[31:0]; end
      FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
      FUNCT3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      FUNCT3_MULHU:  begin up = ua * ub; return up[63:32]; end
      FUNCT3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      FUNCT3_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub;
        return up[31:0];
      end
      FUNCT3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub;
        return up[31:0];
      end
    endcase
  endfunction

  // Expected accept-to-valid edge count; tracks the operand cache when it is built
  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    logic        sgn;
    logic [31:0] ma;
    logic [31:0] mb;
    if (!f3[2]) return 1;
    if (b == 32'd0) return 0;
    sgn = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    ma = (sgn && a[31]) ? 32'(-a) : a;
    mb = (sgn && b[31]) ? 32'(-b) : b;
`ifdef MULDIV_REM_CACHE_EN
    if (cacheValid && ma == cacheA && mb == cacheB) return 0;
    cacheValid = 1'b1;
    cacheA     = ma;
    cacheB     = mb;
`else
    if (cacheValid && ma == cacheA && mb == cacheB) cacheValid = 1'b1;
`endif
    return DIV_LAT;
  endfunction

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input string tag);
    logic [31:0] expC;
    int          expLat;
    int          lat;
    expC   = refResult(f3, a, b);
    expLat = refLatency(f3, a, b);
    lat    = 0;
    checkOutput({tag, " in_ready"}, 64'(bus.in_ready_o), 64'd1);
    bus.funct3_i   = f3;
    bus.rs1_i      = a;
    bus.rs2_i      = b;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.rs1_i      = $urandom;
    bus.rs2_i      = $urandom;
    bus.funct3_i   = 3'($urandom_range(0, 7));
    while (!bus.out_valid_o && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " c_o"}, 64'(bus.c_o), 64'(expC));
    checkOutput({tag, " busy_done"}, 64'(bus.busy_o), 64'd0);
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    checkOutput({tag, " back_idle"}, 64'({bus.in_ready_o, bus.out_valid_o}), 64'b10);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] pool [4];
    pool[0] = 32'd7;
    pool[1] = 32'hFFFF_FFF9;
    pool[2] = 32'd2;
    pool[3] = 32'hFFFF_FFFE;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return pool[$urandom_range(0, 3)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] expHold;
    int          lat;

    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.funct3_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset in_ready", 64'(bus.in_ready_o), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("reset c_o", 64'(bus.c_o), 64'd0);
    checkOutput("reset busy", 64'(bus.busy_o), 64'd0);

    applyStimulus(FUNCT3_MULH,   32'hFFFF_FFFF, 32'h0000_0002, "mulh");
    applyStimulus(FUNCT3_MUL,    32'hFFFF_FFFF, 32'h0000_0002, "mul");
    applyStimulus(FUNCT3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, "div");
    applyStimulus(FUNCT3_REM,    32'hFFFF_FFF9, 32'h0000_0002, "rem");
    applyStimulus(FUNCT3_DIVU,   32'd100,       32'd0,         "divu_zero");
    applyStimulus(FUNCT3_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    applyStimulus(FUNCT3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    applyStimulus(FUNCT3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, "divu_noovf");
    applyStimulus(FUNCT3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, "mulhsu");
    applyStimulus(FUNCT3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, "mulhu");

    // Consumer stall: result must hold and new requests must be ignored
    expHold = refResult(FUNCT3_MULH, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.funct3_i   = FUNCT3_MULH;
    bus.rs1_i      = 32'h1234_5678;
    bus.rs2_i      = 32'h9ABC_DEF0;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.funct3_i = FUNCT3_DIVU;
    bus.rs1_i    = 32'd55;
    bus.rs2_i    = 32'd0;
    lat = 0;
    while (!bus.out_valid_o && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("stall latency", 64'(lat), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall c_o", 64'(bus.c_o), 64'(expHold));
      checkOutput("stall in_ready/out_valid", 64'({bus.in_ready_o, bus.out_valid_o}), 64'b01);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    checkOutput("release no accept", 64'({bus.in_ready_o, bus.out_valid_o}), 64'b10);
    @(posedge clk);
    #1;
    checkOutput("release stays idle", 64'({bus.in_ready_o, bus.out_valid_o, bus.busy_o}), 64'b100);

    // Mid-divide reset aborts the op and drops any cached operands
    applyStimulus(FUNCT3_DIV, 32'd12345, 32'd67, "div_pre_reset");
    bus.funct3_i   = FUNCT3_DIV;
    bus.rs1_i      = 32'd999;
    bus.rs2_i      = 32'd5;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cacheValid = 1'b0;
    checkOutput("abort in_ready", 64'(bus.in_ready_o), 64'd1);
    checkOutput("abort out_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("abort c_o", 64'(bus.c_o), 64'd0);
    checkOutput("abort busy_clr", 64'(bus.busy_o), 64'd0);
    applyStimulus(FUNCT3_DIV, 32'd12345, 32'd67, "div_post_reset");
    applyStimulus(FUNCT3_DIV, 32'd999,   32'd5,  "div_repeat");
    applyStimulus(FUNCT3_REM, 32'd999,   32'd5,  "rem_repeat");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
